// File: rtl/digital_clock_load_ctrl.sv
// Load sequencer for a digital clock: walks hr/min/sec fields of the time or an alarm slot off a shared bus.
// Optional handshake timeout is compiled in with `define DIGITAL_CLOCK_LOAD_TIMEOUT_EN.
module digital_clock_load_ctrl #(
  parameter int NUM_ALARMS     = 2,
  parameter int AW             = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  alarm_req,
  input  logic [AW-1:0]         alarm_sel,
  input  logic                  abort,
  input  logic                  bus_valid,
  output logic                  bus_ready,
  output logic                  ld_hr,
  output logic                  ld_min,
  output logic                  ld_sec,
  output logic                  ld_alarm_hr,
  output logic                  ld_alarm_min,
  output logic                  ld_alarm_sec,
  output logic [AW-1:0]         alarm_idx,
  output logic [NUM_ALARMS-1:0] alarm_armed,
  output logic                  on,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    T_HR  = 3'd1,
    T_MIN = 3'd2,
    T_SEC = 3'd3,
    RUN   = 3'd4,
    A_HR  = 3'd5,
    A_MIN = 3'd6,
    A_SEC = 3'd7
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           alarm_idx_q, alarm_idx_d;
  logic [NUM_ALARMS-1:0]   armed_q, armed_d;
  logic                    err_q, err_d;
  logic                    load_st;
  logic                    hs;
  logic                    sel_ok;
  logic                    abort_eff;

  assign load_st = (state_q != IDLE) && (state_q != RUN);
  assign hs      = bus_valid && load_st && !abort;
  assign sel_ok  = (int'(alarm_sel) < NUM_ALARMS);

`ifdef DIGITAL_CLOCK_LOAD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TW-1:0] cnt_q, cnt_d;
  logic          timeout;

  // A stalled load state behaves exactly like an abort once the budget is spent
  assign timeout   = load_st && !hs && (cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign abort_eff = abort || timeout;

  always_comb begin
    cnt_d = '0;
    if (load_st && !hs && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign abort_eff = abort;
`endif

  always_comb begin
    state_d     = state_q;
    alarm_idx_d = alarm_idx_q;
    armed_d     = armed_q;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = T_HR;
      T_HR: begin
        if (abort_eff) state_d = IDLE;
        else if (hs)   state_d = T_MIN;
      end
      T_MIN: begin
        if (abort_eff) state_d = IDLE;
        else if (hs)   state_d = T_SEC;
      end
      T_SEC: begin
        if (abort_eff) state_d = IDLE;
        else if (hs)   state_d = RUN;
      end
      RUN: begin
        if (start) begin
          state_d = T_HR;
        end else if (alarm_req) begin
          if (sel_ok) begin
            state_d     = A_HR;
            alarm_idx_d = alarm_sel;
            // Slot is disarmed while being rewritten so a partial load never fires
            for (int i = 0; i < NUM_ALARMS; i++) begin
              if (alarm_sel == AW'(i)) armed_d[i] = 1'b0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      A_HR: begin
        if (abort_eff) state_d = RUN;
        else if (hs)   state_d = A_MIN;
      end
      A_MIN: begin
        if (abort_eff) state_d = RUN;
        else if (hs)   state_d = A_SEC;
      end
      A_SEC: begin
        if (abort_eff) begin
          state_d = RUN;
        end else if (hs) begin
          state_d = RUN;
          for (int i = 0; i < NUM_ALARMS; i++) begin
            if (alarm_idx_q == AW'(i)) armed_d[i] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef DIGITAL_CLOCK_LOAD_TIMEOUT_EN
    if (timeout) err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      alarm_idx_q <= '0;
      armed_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      alarm_idx_q <= alarm_idx_d;
      armed_q     <= armed_d;
      err_q       <= err_d;
    end
  end

  assign bus_ready    = load_st;
  assign ld_hr        = hs && (state_q == T_HR);
  assign ld_min       = hs && (state_q == T_MIN);
  assign ld_sec       = hs && (state_q == T_SEC);
  assign ld_alarm_hr  = hs && (state_q == A_HR);
  assign ld_alarm_min = hs && (state_q == A_MIN);
  assign ld_alarm_sec = hs && (state_q == A_SEC);
  assign alarm_idx    = alarm_idx_q;
  assign alarm_armed  = armed_q;
  assign on           = (state_q == RUN) || (state_q == A_HR) ||
                        (state_q == A_MIN) || (state_q == A_SEC);
  assign err          = err_q;

endmodule

// File: doc/digital_clock_load_ctrl.md
DIGITAL_CLOCK_LOAD_CTRL -- requirements
Module: digital_clock_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_ALARMS, 2, number of alarm slots (legal range 1..8).
REQ-002 SHALL have parameter AW, max(1,clog2(NUM_ALARMS)), alarm index width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 255, load-handshake timeout (used only under LOAD_TIMEOUT_EN).
REQ-004 SHALL have ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request time load (hr, min, sec).
- alarm_req  in  1  request alarm load.
- alarm_sel  in  AW  alarm slot for alarm_req.
- abort  in  1  cancel load in progress.
- bus_valid  in  1  shared data bus holds a valid field.
- bus_ready  out  1  sequencer accepts bus field this cycle.
- ld_hr, ld_min, ld_sec  out  1 each  time-field load strobes.
- ld_alarm_hr, ld_alarm_min, ld_alarm_sec  out  1 each  alarm-field load strobes.
- alarm_idx  out  AW  slot targeted by ld_alarm_*.
- alarm_armed  out  NUM_ALARMS  bitmask of fully loaded alarms.
- on  out  1  clock running.
- err  out  1  one-cycle error pulse.

Function
REQ-005 SHALL implement states IDLE, T_HR, T_MIN, T_SEC, RUN, A_HR, A_MIN, A_SEC.
REQ-006 SHALL assert bus_ready combinationally in all T_* and A_* states, and only there.
REQ-007 Handshake = bus_valid && bus_ready && !abort; each handshake SHALL advance one field; no handshake SHALL hold state.
REQ-008 Load strobes SHALL be combinational: ld_<field> high exactly in the handshake cycle of the matching state; at most one strobe high per cycle.
REQ-009 IDLE: on=0; start -> T_HR next cycle; alarm_req ignored.
REQ-010 Sequence T_HR -> T_MIN -> T_SEC -> RUN on successive handshakes; on SHALL rise the cycle after the T_SEC handshake.
REQ-011 RUN: on=1; start -> T_HR with on=0 from next cycle until reload completes; alarm_armed retained.
REQ-012 RUN: alarm_req with alarm_sel < NUM_ALARMS -> A_HR; alarm_idx latched from alarm_sel; alarm_armed[alarm_sel] cleared on the same edge.
REQ-013 RUN: alarm_req with alarm_sel >= NUM_ALARMS SHALL be ignored and pulse err for one cycle.
REQ-014 start and alarm_req together in RUN: start SHALL win.
REQ-015 A_HR -> A_MIN -> A_SEC -> RUN on handshakes; A_SEC handshake SHALL set alarm_armed[alarm_idx] on the same edge; on stays 1 throughout.
REQ-016 alarm_idx SHALL be stable from A_HR entry until RUN re-entry.
REQ-017 abort in any T_* -> IDLE (on=0); abort in any A_* -> RUN with the slot left disarmed; abort beats bus_valid (no strobe that cycle).
REQ-018 start, alarm_req in any load state SHALL be ignored.

Reset
REQ-019 reset_n low SHALL asynchronously force IDLE, on=0, alarm_armed=0, alarm_idx=0, err=0, timeout counter=0; strobes and bus_ready then 0.
REQ-020 Reset asserted mid-load SHALL discard the partial load; first state after release is IDLE.

Configuration
REQ-021 Macro DIGITAL_CLOCK_LOAD_TIMEOUT_EN defined: a counter SHALL clear on state entry and on each handshake, increment each cycle in T_*/A_* without handshake; on reaching TIMEOUT_CYCLES it SHALL act as abort (REQ-017) and pulse err one cycle.
REQ-022 Macro undefined: no counter logic; load states wait indefinitely; err driven only by REQ-013.

Verification
REQ-023 Reset release, start=1 one cycle, bus_valid=1 for 3 cycles -> ld_hr, ld_min, ld_sec pulse in consecutive cycles, on=1 the next cycle.
REQ-024 In RUN, alarm_req=1, alarm_sel=1, bus_valid gapped (1,0,1,0,1) -> ld_alarm_hr/min/sec on cycles 1,3,5, alarm_idx=1, alarm_armed=2'b10 after the last, on stays 1.
REQ-025 NUM_ALARMS=3, alarm_sel=3 in RUN -> err one cycle, state stays RUN, no strobe, alarm_armed unchanged.
REQ-026 In A_MIN of slot 0 (previously armed), abort=1 with bus_valid=1 -> no strobe, RUN next cycle, alarm_armed[0]=0.
REQ-027 reset_n pulsed low during T_MIN -> on=0, alarm_armed=0 immediately, IDLE after release.
REQ-028 With DIGITAL_CLOCK_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4, bus_valid=0 in T_HR -> err pulse and IDLE after 4 cycles; without macro, still T_HR after 100 cycles.
